tcp_tx_patgen: RTL



---
 rtl/tcp_tx_patgen_pkg.sv | 17 +
 rtl/prbs31_byte.sv | 41 ++++
 rtl/tcp_tx_patgen.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/tcp_tx_patgen_pkg.sv
// tcp_tx_patgen_pkg: mode codes, FSM encoding and PRBS seed
// shared by tcp_tx_patgen and prbs31_byte.
package tcp_tx_patgen_pkg;

  localparam logic [1:0] MODE_INC  = 2'd0;
  localparam logic [1:0] MODE_FILL = 2'd1;
  localparam logic [1:0] MODE_PRBS = 2'd2;

  localparam logic [30:0] PRBS_SEED = 31'h7FFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/prbs31_byte.sv
// prbs31_byte: PRBS-31 (x^31+x^28+1), 8 steps per byte.
// LOAD seeds, ADV advances; BYTE is the next byte, first bit in MSB.
module prbs31_byte
  import tcp_tx_patgen_pkg::*;
(
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       LOAD,
  input  logic       ADV,
  output logic [7:0] BYTE
);

  logic [30:0] s_q;
  logic [30:0] s_nx;
  logic [7:0]  b_nx;
  logic        fb;

  always_comb begin
    s_nx = s_q;
    b_nx = 8'h00;
    fb   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fb   = s_nx[30] ^ s_nx[27];
      s_nx = {s_nx[29:0], fb};
      b_nx = {b_nx[6:0], fb};
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      s_q <= PRBS_SEED;
    end else if (LOAD) begin
      s_q <= PRBS_SEED;
    end else if (ADV) begin
      s_q <= s_nx;
    end
  end

  assign BYTE = b_nx;

endmodule

// File: rtl/tcp_tx_patgen.sv
// tcp_tx_patgen: pattern source for the SiTCP TX port (inc/fill/PRBS).
// Ports: START/STOP/MODE/FILL/LENGTH/GAP in, TCP_TX_WR/DATA, BUSY/DONE/SENT_CNT out.
// PRBS-31 mode 2 is built only with TCP_TX_PATGEN_PRBS_EN defined.
module tcp_tx_patgen
  import tcp_tx_patgen_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             TCP_OPEN_ACK,
  input  logic             TCP_TX_FULL,
  input  logic             START,
  input  logic             STOP,
  input  logic [1:0]       MODE,
  input  logic [7:0]       FILL,
  input  logic [CNT_W-1:0] LENGTH,
  input  logic [7:0]       GAP,
  output logic             TCP_TX_WR,
  output logic [7:0]       TCP_TX_DATA,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] SENT_CNT
);

  localparam logic [CNT_W-1:0] ONE = 1;

  state_t           state_q;
  state_t           state_d;
  logic [1:0]       mode_q;
  logic [7:0]       fill_q;
  logic [7:0]       gap_q;
  logic [7:0]       gap_cnt_q;
  logic [7:0]       inc_q;
  logic [7:0]       data_q;
  logic [7:0]       byte_d;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] sent_q;
  logic [CNT_W-1:0] sent_nx;
  logic             wr_q;
  logic             done_q;
  logic             abort;
  logic             start_ok;
  logic             issue;
  logic             last;

  assign abort   = STOP | ~TCP_OPEN_ACK;
  assign sent_nx = sent_q + ONE;
  assign last    = (len_q != '0) && (sent_nx == len_q);

  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    issue    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // done_q keeps BUSY up for the final write cycle
        if (START && !abort && !done_q) begin
          state_d  = ST_RUN;
          start_ok = 1'b1;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (!TCP_TX_FULL) begin
          issue = 1'b1;
          if (last) begin
            state_d = ST_IDLE;
          end else if (gap_q != 8'd0) begin
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (gap_cnt_q <= 8'd1) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef TCP_TX_PATGEN_PRBS_EN
  logic [7:0] prbs_byte;

  prbs31_byte u_prbs (
    .CLK  (CLK),
    .RSTn (RSTn),
    .LOAD (start_ok),
    .ADV  (issue && (mode_q == MODE_PRBS)),
    .BYTE (prbs_byte)
  );
`endif

  always_comb begin
    byte_d = inc_q;
    if (mode_q == MODE_FILL) begin
      byte_d = fill_q;
    end
`ifdef TCP_TX_PATGEN_PRBS_EN
    else if (mode_q == MODE_PRBS) begin
      byte_d = prbs_byte;
    end
`endif
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      mode_q    <= MODE_INC;
      fill_q    <= 8'h00;
      gap_q     <= 8'h00;
      gap_cnt_q <= 8'h00;
      inc_q     <= 8'h00;
      data_q    <= 8'h00;
      len_q     <= '0;
      sent_q    <= '0;
      wr_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      wr_q   <= issue;
      done_q <= issue & last;
      if (start_ok) begin
        mode_q <= MODE;
        fill_q <= FILL;
        len_q  <= LENGTH;
        gap_q  <= GAP;
        sent_q <= '0;
        inc_q  <= 8'h00;
      end
      if (issue) begin
        data_q    <= byte_d;
        sent_q    <= sent_nx;
        inc_q     <= inc_q + 8'd1;
        gap_cnt_q <= gap_q;
      end else if (state_q == ST_GAP) begin
        gap_cnt_q <= gap_cnt_q - 8'd1;
      end
    end
  end

  assign TCP_TX_WR   = wr_q;
  assign TCP_TX_DATA = data_q;
  assign DONE        = done_q;
  assign BUSY        = (state_q != ST_IDLE) | done_q;
  assign SENT_CNT    = sent_q;

endmodule
